// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller with IDCODE, BYPASS and one external debug chain.
// FSM and shift registers advance on rising tck; tdo/tdo_oe are launched on falling tck.
module jtag_tap #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h149511c3,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(4'b0010),
  parameter logic [IR_WIDTH-1:0] DEBUG_INSTR  = IR_WIDTH'(4'b1000),
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = IR_WIDTH'(4'b1111)
) (
  input  logic tck,
  input  logic trst_n,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_oe,
  output logic test_logic_reset,
  output logic run_test_idle,
  output logic capture_dr,
  output logic shift_dr,
  output logic pause_dr,
  output logic update_dr,
  output logic debug_select,
  output logic debug_tdi,
  input  logic debug_tdo
);

  typedef enum logic [3:0] {
    StTestLogicReset,
    StRunTestIdle,
    StSelectDr,
    StCaptureDr,
    StShiftDr,
    StExit1Dr,
    StPauseDr,
    StExit2Dr,
    StUpdateDr,
    StSelectIr,
    StCaptureIr,
    StShiftIr,
    StExit1Ir,
    StPauseIr,
    StExit2Ir,
    StUpdateIr
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IrCaptureValue = IR_WIDTH'(2'b01);

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic                sel_idcode, sel_debug;

  // BYPASS_INSTR and every undefined opcode share the bypass path.
  assign sel_idcode = (ir_q == IDCODE_INSTR);
  assign sel_debug  = (ir_q == DEBUG_INSTR) && (DEBUG_INSTR != BYPASS_INSTR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTestLogicReset: state_d = tms ? StTestLogicReset : StRunTestIdle;
      StRunTestIdle:    state_d = tms ? StSelectDr       : StRunTestIdle;
      StSelectDr:       state_d = tms ? StSelectIr       : StCaptureDr;
      StCaptureDr:      state_d = tms ? StExit1Dr        : StShiftDr;
      StShiftDr:        state_d = tms ? StExit1Dr        : StShiftDr;
      StExit1Dr:        state_d = tms ? StUpdateDr       : StPauseDr;
      StPauseDr:        state_d = tms ? StExit2Dr        : StPauseDr;
      StExit2Dr:        state_d = tms ? StUpdateDr       : StShiftDr;
      StUpdateDr:       state_d = tms ? StSelectDr       : StRunTestIdle;
      StSelectIr:       state_d = tms ? StTestLogicReset : StCaptureIr;
      StCaptureIr:      state_d = tms ? StExit1Ir        : StShiftIr;
      StShiftIr:        state_d = tms ? StExit1Ir        : StShiftIr;
      StExit1Ir:        state_d = tms ? StUpdateIr       : StPauseIr;
      StPauseIr:        state_d = tms ? StExit2Ir        : StPauseIr;
      StExit2Ir:        state_d = tms ? StUpdateIr       : StShiftIr;
      StUpdateIr:       state_d = tms ? StSelectDr       : StRunTestIdle;
    endcase
  end

  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;

    unique case (state_q)
      StTestLogicReset: ir_d       = IDCODE_INSTR;
      StCaptureIr:      ir_shift_d = IrCaptureValue;
      StShiftIr:        ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
      StUpdateIr:       ir_d       = ir_shift_q;
      StCaptureDr: begin
        if (sel_idcode) begin
          idcode_d = IDCODE_VALUE;
        end else if (!sel_debug) begin
          bypass_d = 1'b0;
        end
      end
      StShiftDr: begin
        if (sel_idcode) begin
          idcode_d = {tdi, idcode_q[31:1]};
        end else if (!sel_debug) begin
          bypass_d = tdi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q    <= StTestLogicReset;
      ir_shift_q <= IDCODE_INSTR;
      ir_q       <= IDCODE_INSTR;
      bypass_q   <= 1'b0;
      idcode_q   <= IDCODE_VALUE;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
    end
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_oe_d = 1'b0;
    if (state_q == StShiftIr) begin
      tdo_d    = ir_shift_q[0];
      tdo_oe_d = 1'b1;
    end else if (state_q == StShiftDr) begin
      tdo_oe_d = 1'b1;
      if (sel_idcode) begin
        tdo_d = idcode_q[0];
      end else if (sel_debug) begin
        tdo_d = debug_tdo;
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  // Falling-edge launch keeps tdo stable across the rising edge where the master samples it.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tdo              = tdo_q;
  assign tdo_oe           = tdo_oe_q;
  assign test_logic_reset = (state_q == StTestLogicReset);
  assign run_test_idle    = (state_q == StRunTestIdle);
  assign capture_dr       = (state_q == StCaptureDr);
  assign shift_dr         = (state_q == StShiftDr);
  assign pause_dr         = (state_q == StPauseDr);
  assign update_dr        = (state_q == StUpdateDr);
  assign debug_select     = sel_debug;
  assign debug_tdi        = tdi;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: queue-based TAP model checked every falling tck,
// directed scans with hand-computed results, then a randomized tms/tdi/trst_n walk.
module tb_jtag_tap;

  localparam logic [31:0] IdValue     = 32'h149511c3;
  localparam logic [3:0]  IdcodeInstr = 4'b0010;
  localparam logic [3:0]  DebugInstr  = 4'b1000;

  // Model states use the IEEE 1149.1 reference codes.
  localparam int Ex2Dr = 4'h0, Ex1Dr = 4'h1, ShDr = 4'h2, PauDr = 4'h3, SelIr = 4'h4;
  localparam int UpdDr = 4'h5, CapDr = 4'h6, SelDr = 4'h7, Ex2Ir = 4'h8, Ex1Ir = 4'h9;
  localparam int ShIr = 4'hA, PauIr = 4'hB, Rti = 4'hC, UpdIr = 4'hD, CapIr = 4'hE, Tlr = 4'hF;

  logic tck = 1'b0, trst_n = 1'b1, tms = 1'b1, tdi = 1'b0, debug_tdo = 1'b0;
  logic tdo, tdo_oe, test_logic_reset, run_test_idle, capture_dr, shift_dr, pause_dr;
  logic update_dr, debug_select, debug_tdi;

  int   checks = 0, failures = 0;
  bit   debug_loop = 1'b0;

  int         nx0 [16];
  int         nx1 [16];
  int         m_st;
  logic [3:0] m_ir;
  bit         irq[$];
  bit         drq[$];

  jtag_tap dut (
    .tck              (tck),
    .trst_n           (trst_n),
    .tms              (tms),
    .tdi              (tdi),
    .tdo              (tdo),
    .tdo_oe           (tdo_oe),
    .test_logic_reset (test_logic_reset),
    .run_test_idle    (run_test_idle),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .pause_dr         (pause_dr),
    .update_dr        (update_dr),
    .debug_select     (debug_select),
    .debug_tdi        (debug_tdi),
    .debug_tdo        (debug_tdo)
  );

  always #5 tck = ~tck;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  initial begin
    nx0[Tlr] = Rti;   nx1[Tlr] = Tlr;   nx0[Rti] = Rti;   nx1[Rti] = SelDr;
    nx0[SelDr] = CapDr; nx1[SelDr] = SelIr; nx0[SelIr] = CapIr; nx1[SelIr] = Tlr;
    nx0[CapDr] = ShDr;  nx1[CapDr] = Ex1Dr; nx0[ShDr] = ShDr;   nx1[ShDr] = Ex1Dr;
    nx0[Ex1Dr] = PauDr; nx1[Ex1Dr] = UpdDr; nx0[PauDr] = PauDr; nx1[PauDr] = Ex2Dr;
    nx0[Ex2Dr] = ShDr;  nx1[Ex2Dr] = UpdDr; nx0[UpdDr] = Rti;   nx1[UpdDr] = SelDr;
    nx0[CapIr] = ShIr;  nx1[CapIr] = Ex1Ir; nx0[ShIr] = ShIr;   nx1[ShIr] = Ex1Ir;
    nx0[Ex1Ir] = PauIr; nx1[Ex1Ir] = UpdIr; nx0[PauIr] = PauIr; nx1[PauIr] = Ex2Ir;
    nx0[Ex2Ir] = ShIr;  nx1[Ex2Ir] = UpdIr; nx0[UpdIr] = Rti;   nx1[UpdIr] = SelDr;
  end

  // Registers modelled as bit queues: front is the bit on tdo, tdi joins at the back.
  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      m_st = Tlr;
      m_ir = IdcodeInstr;
      irq.delete();
      drq.delete();
    end else begin
      if (m_st == Tlr) m_ir = IdcodeInstr;
      if (m_st == CapIr) begin
        irq.delete();
        irq.push_back(1'b1);
        for (int i = 1; i < 4; i++) irq.push_back(1'b0);
      end
      if (m_st == ShIr) begin
        void'(irq.pop_front());
        irq.push_back(tdi);
      end
      if (m_st == UpdIr) begin
        m_ir = 4'b0;
        for (int i = 0; i < 4; i++) if (irq[i]) m_ir = m_ir + 4'(1 << i);
      end
      if (m_st == CapDr) begin
        drq.delete();
        if (m_ir == IdcodeInstr) for (int i = 0; i < 32; i++) drq.push_back(IdValue[i]);
        else if (m_ir != DebugInstr) drq.push_back(1'b0);
      end
      if (m_st == ShDr && m_ir != DebugInstr) begin
        void'(drq.pop_front());
        drq.push_back(tdi);
      end
      m_st = tms ? nx1[m_st] : nx0[m_st];
    end
  end

  always @(negedge tck) begin
    bit etdo, eoe;
    etdo = 1'b0;
    eoe  = 1'b0;
    if (trst_n) begin
      if (m_st == ShIr) begin
        eoe  = 1'b1;
        etdo = irq[0];
      end else if (m_st == ShDr) begin
        eoe  = 1'b1;
        etdo = (m_ir == DebugInstr) ? debug_tdo : drq[0];
      end
    end
    #1;
    check("tdo", tdo, etdo);
    check("tdo_oe", tdo_oe, eoe);
    check("test_logic_reset", test_logic_reset, m_st == Tlr);
    check("run_test_idle", run_test_idle, m_st == Rti);
    check("capture_dr", capture_dr, m_st == CapDr);
    check("shift_dr", shift_dr, m_st == ShDr);
    check("pause_dr", pause_dr, m_st == PauDr);
    check("update_dr", update_dr, m_st == UpdDr);
    check("debug_select", debug_select, m_ir == DebugInstr);
  end

  task automatic tick(input bit t_ms, input bit t_di, output bit out);
    @(negedge tck);
    #1;
    out = tdo;
    tms = t_ms;
    tdi = t_di;
    debug_tdo = debug_loop ? ~t_di : 1'($urandom);
    @(posedge tck);
    #1;
  endtask

  task automatic do_reset();
    @(negedge tck);
    #2 trst_n = 1'b0;
    #1;
    check("rst_tlr", test_logic_reset, 1'b1);
    check("rst_tdo", tdo, 1'b0);
    check("rst_tdo_oe", tdo_oe, 1'b0);
    check("rst_debug_select", debug_select, 1'b0);
    @(negedge tck);
    #2 trst_n = 1'b1;
  endtask

  // Both scans start and end in Run-Test/Idle.
  task automatic scan_ir(input logic [3:0] v, output logic [3:0] out);
    bit o;
    tick(1, 0, o); tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, v[i], o);
      out[i] = o;
    end
    tick(1, 0, o); tick(0, 0, o);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] v, output logic [31:0] out);
    bit o;
    out = '0;
    tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, v[i], o);
      out[i] = o;
    end
    tick(1, 0, o); tick(0, 0, o);
  endtask

  initial begin
    bit          o;
    logic [3:0]  ir_out;
    logic [31:0] dr_out;

    #1 trst_n = 1'b0;
    #12;
    check("init_tlr", test_logic_reset, 1'b1);
    check("init_tdo_oe", tdo_oe, 1'b0);
    @(negedge tck);
    #2 trst_n = 1'b1;
    tick(0, 0, o);
    check("tp1_tlr_low", test_logic_reset, 1'b0);
    check("tp1_rti", run_test_idle, 1'b1);
    tick(0, 0, o); tick(0, 0, o);
    check("tp1_tdo", tdo, 1'b0);

    scan_dr(32, 32'h0, dr_out);
    check("idcode_scan", dr_out, 32'h149511c3);

    scan_ir(4'b1111, ir_out);
    check("ir_capture_out", ir_out, 4'b0001);
    scan_dr(8, 32'hA5, dr_out);
    check("bypass_a5", dr_out, 32'h4A);

    scan_ir(4'b1000, ir_out);
    check("debug_select_set", debug_select, 1'b1);
    debug_loop = 1'b1;
    scan_dr(8, 32'h3C, dr_out);
    debug_loop = 1'b0;
    check("debug_chain", dr_out, 32'h87);

    tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
    for (int i = 0; i < 4; i++) tick(1, 0, o);
    check("tms4_not_tlr", test_logic_reset, 1'b0);
    tick(1, 0, o);
    check("tms5_tlr", test_logic_reset, 1'b1);
    tick(1, 0, o);
    check("tlr_debug_select", debug_select, 1'b0);
    tick(0, 0, o);

    scan_ir(4'b0101, ir_out);
    scan_dr(8, 32'hC3, dr_out);
    check("undef_bypass_c3", dr_out, 32'h86);

    tick(1, 0, o); tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
    tick(0, 1, o); tick(0, 0, o);
    do_reset();
    tick(0, 0, o);
    scan_dr(32, 32'h0, dr_out);
    check("ir_idcode_after_trst", dr_out, 32'h149511c3);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick($urandom_range(0, 99) < 30, 1'($urandom), o);
    end

    @(negedge tck);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
Name: jtag_tap

Overview:
- IEEE 1149.1 TAP controller: the simulation-side JTAG slave that consumes the tck/tms/tdi stream from the JTAG VPI master and returns tdo.
- Holds the 16-state TAP FSM, an instruction register, and IDCODE and BYPASS data registers.
- Exposes a select/strobe interface that attaches one user debug chain (e.g. a debug unit) behind a DEBUG instruction.

Parameters:
- IR_WIDTH, 4, instruction register width (>= 2).
- IDCODE_VALUE, 32'h149511c3, value loaded into the IDCODE register on Capture-DR; bit 0 must be 1.
- IDCODE_INSTR, 4'b0010, IDCODE opcode; also the reset instruction.
- DEBUG_INSTR, 4'b1000, opcode selecting the external debug chain.
- BYPASS_INSTR, 4'b1111, BYPASS opcode. Any undefined opcode also behaves as BYPASS.

Ports:
- tck  input  1  JTAG clock; the only clock. Rising edge for FSM and shift registers, falling edge for tdo.
- trst_n  input  1  asynchronous active-low reset.
- tms  input  1  test mode select, sampled on rising tck.
- tdi  input  1  serial data in, sampled on rising tck.
- tdo  output  1  serial data out, updated on falling tck.
- tdo_oe  output  1  high while in Shift-IR or Shift-DR (registered with tdo).
- test_logic_reset  output  1  FSM is in Test-Logic-Reset.
- run_test_idle  output  1  FSM is in Run-Test/Idle.
- capture_dr  output  1  FSM is in Capture-DR.
- shift_dr  output  1  FSM is in Shift-DR.
- pause_dr  output  1  FSM is in Pause-DR.
- update_dr  output  1  FSM is in Update-DR.
- debug_select  output  1  latched IR == DEBUG_INSTR.
- debug_tdi  output  1  tdi forwarded combinationally to the debug chain.
- debug_tdo  input  1  serial output of the debug chain.

Behaviour:
- Reset (trst_n low, asynchronous):
  - state = TEST_LOGIC_RESET; IR shift and latched IR = IDCODE_INSTR; bypass = 0; IDCODE shift = IDCODE_VALUE.
  - tdo = 0, tdo_oe = 0, debug_select = 0, test_logic_reset = 1.
- FSM: the standard 16 states, transitions on rising tck per tms:
  - TLR: tms=1 -> TLR, tms=0 -> RTI.
  - RTI: 0 -> RTI, 1 -> SelDR.
  - SelDR: 0 -> CapDR, 1 -> SelIR.
  - SelIR: 0 -> CapIR, 1 -> TLR.
  - Cap*: 0 -> Shift*, 1 -> Exit1*.
  - Shift*: 0 -> Shift*, 1 -> Exit1*.
  - Exit1*: 0 -> Pause*, 1 -> Update*.
  - Pause*: 0 -> Pause*, 1 -> Exit2*.
  - Exit2*: 0 -> Shift*, 1 -> Update*.
  - Update*: 0 -> RTI, 1 -> SelDR.
  - Five consecutive tms=1 clocks reach TLR from any state.
- State outputs decode the current state combinationally; no added latency.
- While in TLR, the latched IR is forced to IDCODE_INSTR on every rising edge.
- IR path:
  - Capture-IR loads IR shift with {zeros, 2'b01}.
  - Shift-IR shifts right: tdi enters the MSB, LSB drives tdo.
  - On the rising edge that leaves Update-IR, the latched IR takes IR shift.
- DR selection by latched IR:
  - IDCODE: Capture-DR loads IDCODE_VALUE; Shift-DR shifts right with tdi into bit 31.
  - BYPASS or undefined: Capture-DR clears the 1-bit register; Shift-DR loads tdi.
  - DEBUG: the chain is external; tdo source is debug_tdo.
- tdo timing:
  - On falling tck in Shift-IR, tdo = IR shift[0].
  - In Shift-DR, tdo = LSB of the selected DR (bypass bit, IDCODE[0], or debug_tdo).
  - Otherwise tdo = 0, tdo_oe = 0.
  - tdo is therefore stable across the following rising edge, where the master samples it.
- Bit latency:
  - BYPASS: one bit of delay tdi -> tdo.
  - IDCODE: the first 32 bits out are IDCODE_VALUE, LSB first.
- Shift-DR with tms=1 on the final bit shifts that bit and exits (flip-TMS scans).
- Pause/Exit2 hold all shift registers; shifting resumes without loss.
- trst_n asserted mid-shift: immediate return to reset values; partial IR is discarded, latched IR = IDCODE_INSTR.

Test Plan:
- Pulse trst_n low, then 3 tck with tms=0 -> test_logic_reset 1 then 0, run_test_idle=1, tdo=0, tdo_oe=0.
- From Shift-DR, clock 5 tck with tms=1 -> TLR reached on the 5th edge; debug_select=0; latched IR = 4'b0010.
- After reset, navigate to Shift-DR and shift 32 bits of tdi=0 -> captured tdo sequence = 32'h149511c3, LSB first.
- Navigate to Shift-IR, shift 1111 with tms=1 on the 4th bit -> tdo bits 1,0,0,0. After Update-IR, shift DR 8 bits 8'hA5 -> tdo = 0 followed by A5 delayed one bit.
- Load IR 4'b1000 -> debug_select=1. In Shift-DR, drive debug_tdo = ~debug_tdi -> tdo reflects debug_tdo per falling edge; shift_dr, capture_dr and update_dr each pulse for exactly their states.
- Load IR 4'b0101 (undefined) -> BYPASS behaviour. Assert trst_n low mid-Shift-IR -> immediate TLR, tdo_oe=0, IR = IDCODE.
